// File: rtl/normalize_scheduler.sv
// normalize_scheduler: a leading-zero count and normalize shift datapath shared by
// two requesters. Requester 0 is the add/sub unit and requester 1 is the mul/div unit.
// Arbitration is round-robin. The datapath has two stages: S1 counts leading zeros and
// S2 shifts. Each result carries its source id and tag.
// Optional feature: define NORM_SCHED_STATS_EN to add the saturating
// stat_conflicts and stat_stalls counters.
module normalize_scheduler #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag
`ifdef NORM_SCHED_STATS_EN
    ,
    output logic [15:0]      stat_conflicts,
    output logic [15:0]      stat_stalls
`endif
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned LVLS = $clog2(NIB);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s1_src_q;
    logic             rr_q;      // id of the last granted requester
    logic             rr_set_q;  // clear until the first grant after reset, so req0 wins first
    logic             any_valid;
    logic             gnt;
    logic             s1_free;
    logic             s1_advance;
    logic             s2_advance;
    logic             accept;
    logic [CNT_W-1:0] s1_cnt;
    logic             s1_zero;

    function automatic logic [2:0] nib_lz(input logic [3:0] n);
        if (n[3])      return 3'd0;
        else if (n[2]) return 3'd1;
        else if (n[1]) return 3'd2;
        else if (n[0]) return 3'd3;
        else           return 3'd4;
    endfunction

    // Grant uses only the valids and the rr pointer. Ready never feeds back into it.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt = rr_set_q ? ~rr_q : 1'b0;
        end else if (req1_valid) begin
            gnt = 1'b1;
        end
    end

    assign any_valid  = req0_valid | req1_valid;
    assign s2_advance = ~out_valid | out_ready;
    assign s1_advance = s1_valid_q & s2_advance;
    assign s1_free    = ~s1_valid_q | s1_advance;
    assign accept     = any_valid & s1_free;
    assign req0_ready = s1_free & req0_valid & ~gnt;
    assign req1_ready = s1_free & req1_valid & gnt;

    // The round-robin pointer moves only when a transfer is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q     <= 1'b0;
            rr_set_q <= 1'b0;
        end else if (accept) begin
            rr_q     <= gnt;
            rr_set_q <= 1'b1;
        end
    end

    // S1 register: capture the granted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s1_src_q   <= 1'b0;
        end else if (s1_free) begin
            s1_valid_q <= any_valid;
            if (any_valid) begin
                s1_data_q <= gnt ? req1_data : req0_data;
                s1_tag_q  <= gnt ? req1_tag : req0_tag;
                s1_src_q  <= gnt;
            end
        end
    end

    // Leading-zero tree. Level 0 counts per nibble. Each higher level merges pairs of
    // nodes: when the upper half is all zero, the lower count is added to the half width.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        localparam int unsigned N = NIB >> l;
        logic [N-1:0][CNT_W-1:0] cnt;
        logic [N-1:0]            zero;
        for (genvar i = 0; i < N; i++) begin : g_node
            if (l == 0) begin : g_leaf
                assign cnt[i]  = CNT_W'(nib_lz(s1_data_q[4*i +: 4]));
                assign zero[i] = (s1_data_q[4*i +: 4] == 4'd0);
            end else begin : g_join
                assign zero[i] = g_lvl[l-1].zero[2*i] & g_lvl[l-1].zero[2*i+1];
                assign cnt[i]  = g_lvl[l-1].zero[2*i+1]
                               ? CNT_W'(4 << (l - 1)) + g_lvl[l-1].cnt[2*i]
                               : g_lvl[l-1].cnt[2*i+1];
            end
        end
    end

    assign s1_cnt  = g_lvl[LVLS].cnt[0];
    assign s1_zero = g_lvl[LVLS].zero[0];

    // S2 register: shift and present the result. It holds while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_zero  <= 1'b0;
            out_src   <= 1'b0;
            out_tag   <= '0;
        end else if (s2_advance) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_data  <= s1_data_q << s1_cnt;
                out_count <= s1_cnt;
                out_zero  <= s1_zero;
                out_src   <= s1_src_q;
                out_tag   <= s1_tag_q;
            end
        end
    end

`ifdef NORM_SCHED_STATS_EN
    // Saturating activity counters: request conflicts and output stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_conflicts <= 16'd0;
            stat_stalls    <= 16'd0;
        end else begin
            if (req0_valid && req1_valid && stat_conflicts != 16'hFFFF) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
            if (out_valid && !out_ready && stat_stalls != 16'hFFFF) begin
                stat_stalls <= stat_stalls + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built.
`endif

endmodule
